ibex_sec_erase_seq: RTL and testbench

Multi-cycle sequencer that executes the secure register-erasure instructions (`OPCODE_SEC_ERSL` for x0–x15 and `OPCODE_SEC_ERSH` for x16–x31). It sits between the ID-stage decoder, which supplies the bank select and a 16-bit register mask, and the register-file write port, where it issues one erasure write per cycle. It stalls the pipeline while active. Optionally, it overwrites registers with LFSR data instead of zero.

---
 rtl/ibex_sec_erase_seq.sv | 145 ++++++++++++++
 tb/tb_ibex_sec_erase_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_sec_erase_seq.sv
`default_nettype none
// ============================================================================
// Module   : ibex_sec_erase_seq
// Purpose  : Multi-cycle sequencer for the secure register-erasure
//            instructions (SEC_ERSL: x0-x15, SEC_ERSH: x16-x31). It issues
//            one register-file write per accepted cycle, stalls the ID stage
//            while active and pulses done_o on completion.
// Options  : IBEX_SEC_ERASE_LFSR_EN - when defined, erased registers are
//            overwritten with Galois-LFSR data instead of zero.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_sec_erase_seq #(
  parameter logic [31:0] LfsrSeed = 32'hACE1_2468,
  parameter logic [31:0] LfsrTaps = 32'h8020_0003
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        hi_i,
  input  logic [15:0] mask_i,
  input  logic        kill_i,
  input  logic        rf_ready_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ERASE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] mask_q,  mask_d;
  logic        hi_q,    hi_d;

  logic [3:0]  w_idx;
  logic [15:0] w_start_mask;
  logic [15:0] w_mask_cleared;
  logic        w_erasing;
  logic        w_accept;

  // Low bank never writes x0, so bit 0 is dropped before the mask is latched.
  assign w_start_mask   = hi_i ? mask_i : {mask_i[15:1], 1'b0};
  // Clearing the lowest set bit is the same as clearing mask_q[w_idx].
  assign w_mask_cleared = mask_q & (mask_q - 16'd1);
  assign w_erasing      = (state_q == ERASE);
  assign w_accept       = rf_we_o & rf_ready_i;

  // Priority encoder: lowest set bit of the remaining mask wins.
  always_comb begin
    w_idx = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (mask_q[k]) begin
        w_idx = k[3:0];
      end
    end
  end

  // Next-state logic; a flush overrides everything and drops the mask.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    hi_d    = hi_q;
    if (kill_i) begin
      state_d = IDLE;
      mask_d  = 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            hi_d    = hi_i;
            mask_d  = w_start_mask;
            state_d = (w_start_mask != 16'h0000) ? ERASE : DONE;
          end
        end
        ERASE: begin
          if (rf_ready_i) begin
            mask_d = w_mask_cleared;
            if (w_mask_cleared == 16'h0000) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          mask_d  = 16'h0000;
        end
      endcase
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mask_q  <= 16'h0000;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      hi_q    <= hi_d;
    end
  end

  // Write request is registered-state driven; only the flush gates it combinationally.
  assign rf_we_o    = w_erasing & ~kill_i;
  assign rf_waddr_o = w_erasing ? {hi_q, w_idx} : 5'd0;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);

`ifdef IBEX_SEC_ERASE_LFSR_EN
  logic [31:0] lfsr_q, lfsr_d;

  // One Galois step per accepted write; a flush leaves the LFSR untouched.
  always_comb begin
    lfsr_d = lfsr_q;
    if (w_accept) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrTaps : 32'h0000_0000);
    end
  end

  // LFSR register, reseeded only by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rf_wdata_o = w_erasing ? lfsr_q : 32'h0000_0000;
`else
  // Zero-fill build: no LFSR state exists, the parameters are intentionally idle.
  logic unused_lfsr_cfg;
  assign unused_lfsr_cfg = ^{LfsrSeed, LfsrTaps, w_accept};
  assign rf_wdata_o      = 32'h0000_0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ibex_sec_erase_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_sec_erase_seq
// Purpose  : Self-checking bench for ibex_sec_erase_seq. A queue of pending
//            register indices models the erase sequence cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_sec_erase_seq;

  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        hi_i;
  logic [15:0] mask_i;
  logic        kill_i;
  logic        rf_ready_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        busy_o;
  logic        done_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_lfsr;

  ibex_sec_erase_seq #(.LfsrSeed(SEED), .LfsrTaps(TAPS)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .hi_i       (hi_i),
    .mask_i     (mask_i),
    .kill_i     (kill_i),
    .rf_ready_i (rf_ready_i),
    .rf_we_o    (rf_we_o),
    .rf_waddr_o (rf_waddr_o),
    .rf_wdata_o (rf_wdata_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] galois(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 32'h0);
  endfunction

  function automatic logic [31:0] exp_data();
`ifdef IBEX_SEC_ERASE_LFSR_EN
    return m_lfsr;
`else
    return 32'h0;
`endif
  endfunction

  // Full erase transaction: start, then compare every cycle against the queue model.
  task automatic run_seq(input logic hi, input logic [15:0] mask, input logic [63:0] stall,
                         input bit rnd, input int kill_at, input string name);
    int   q[$];
    int   c;
    int   head;
    bit   finished;
    logic ready;
    logic exp_we, exp_done;
    logic [4:0] exp_addr;
    for (int k = 0; k < 16; k++)
      if (mask[k] && !(hi == 1'b0 && k == 0)) q.push_back(k);
    @(posedge clk_i); #1;
    start_i = 1'b1; hi_i = hi; mask_i = mask; kill_i = 1'b0; rf_ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; hi_i = 1'($urandom); mask_i = 16'($urandom);
    c = 1;
    finished = 1'b0;
    while (!finished) begin
      if (c > 200) begin
        n_tests++; n_fail++;
        $display("FAIL %s timeout: no completion within 200 cycles", name);
        break;
      end
      ready = rnd ? ($urandom_range(0, 2) != 0) : ((c <= 64) ? !stall[c-1] : 1'b1);
      rf_ready_i = ready;
      kill_i = (c == kill_at);
      #1;
      exp_we   = (q.size() != 0) && !kill_i;
      exp_done = (q.size() == 0);
      n_tests++;
      if (rf_we_o !== exp_we) begin
        n_fail++;
        $display("FAIL %s we c=%0d: got %b expected %b", name, c, rf_we_o, exp_we);
      end
      n_tests++;
      if (done_o !== exp_done || busy_o !== 1'b1) begin
        n_fail++;
        $display("FAIL %s done/busy c=%0d: got %b/%b expected %b/1", name, c, done_o, busy_o, exp_done);
      end
      if (exp_we) begin
        head = q[0];
        exp_addr = {hi, head[3:0]};
        n_tests++;
        if (rf_waddr_o !== exp_addr || rf_wdata_o !== exp_data()) begin
          n_fail++;
          $display("FAIL %s addr/data c=%0d: got x%0d/%h expected x%0d/%h",
                   name, c, rf_waddr_o, rf_wdata_o, exp_addr, exp_data());
        end
      end
      if (kill_i) finished = 1'b1;
      else if (q.size() != 0) begin
        if (ready) begin
          void'(q.pop_front());
          m_lfsr = galois(m_lfsr);
        end
      end else finished = 1'b1;
      @(posedge clk_i); #1;
      c++;
    end
    kill_i = 1'b0; rf_ready_i = 1'b1;
    #1;
    n_tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || rf_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: got busy=%b done=%b we=%b expected 0/0/0", name, busy_o, done_o, rf_we_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; start_i = 1'b0; hi_i = 1'b0; mask_i = 16'h0; kill_i = 1'b0; rf_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    n_tests++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o, busy_o, done_o} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset outputs: got we=%b addr=%0d data=%h busy=%b done=%b expected all 0",
               rf_we_o, rf_waddr_o, rf_wdata_o, busy_o, done_o);
    end
    rst_ni = 1'b1;
    m_lfsr = SEED;
  endtask

  task automatic test_reset_mid();
    @(posedge clk_i); #1;
    start_i = 1'b1; hi_i = 1'b1; mask_i = 16'hFFFF;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    m_lfsr = SEED;
    n_tests++;
    if (busy_o !== 1'b0 || rf_we_o !== 1'b0 || done_o !== 1'b0 || rf_waddr_o !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b we=%b done=%b addr=%0d expected 0", busy_o, rf_we_o, done_o, rf_waddr_o);
    end
  endtask

  task automatic test_lfsr();
    logic [31:0] e1, e2;
`ifdef IBEX_SEC_ERASE_LFSR_EN
    e1 = 32'hACE1_2468; e2 = 32'h5670_9234;
`else
    e1 = 32'h0; e2 = 32'h0;
`endif
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    m_lfsr = SEED;
    start_i = 1'b1; hi_i = 1'b0; mask_i = 16'h0006; rf_ready_i = 1'b1; kill_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    #1;
    n_tests++;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd1 || rf_wdata_o !== e1) begin
      n_fail++;
      $display("FAIL lfsr first: got we=%b x%0d %h expected 1 x1 %h", rf_we_o, rf_waddr_o, rf_wdata_o, e1);
    end
    @(posedge clk_i); #2;
    n_tests++;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd2 || rf_wdata_o !== e2) begin
      n_fail++;
      $display("FAIL lfsr second: got we=%b x%0d %h expected 1 x2 %h", rf_we_o, rf_waddr_o, rf_wdata_o, e2);
    end
    m_lfsr = galois(galois(m_lfsr));
    repeat (2) @(posedge clk_i);
    #1;
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lfsr idle: got busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_random();
    int kat;
    for (int i = 0; i < 25; i++) begin
      kat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : -1;
      run_seq(1'($urandom), 16'($urandom), 64'h0, 1'b1, kat, "random");
    end
  endtask

  initial begin
    test_reset();
    run_seq(1'b0, 16'h8005, 64'h0, 1'b0, -1, "low_8005");
    run_seq(1'b1, 16'hFFFF, 64'h0, 1'b0, -1, "high_ffff");
    run_seq(1'b1, 16'h0012, 64'h3, 1'b0, -1, "stall_0012");
    run_seq(1'b0, 16'h0001, 64'h0, 1'b0, -1, "low_0001");
    run_seq(1'b1, 16'h0000, 64'h0, 1'b0, -1, "high_0000");
    run_seq(1'b0, 16'h00F0, 64'h0, 1'b0, 2, "kill_00f0");
    run_seq(1'b0, 16'h0002, 64'h0, 1'b0, -1, "after_kill");
    test_reset_mid();
    test_lfsr();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
